// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multi-cycle MIPS controller.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP state.
package multicycle_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;
  localparam int unsigned CNT_W  = 32;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [FUNC_W-1:0] FN_NOP = 6'b000000;
  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_J,
    CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_WB_MEM,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  // Full set of datapath controls driven each cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    pc_source_t pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal_op;
  } ctl_t;

endpackage

// File: rtl/multicycle_decode.sv
// multicycle_decode: combinational classification of opcode/funct into an
// instruction class consumed by the sequencing FSM.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic [OP_W-1:0]   op_in,
  input  logic [FUNC_W-1:0] func_in,
  output instr_class_t      instr_class_c
);

  // Map op/funct to class; anything not recognised is ILLEGAL
  always_comb begin
    instr_class_c = CLS_ILLEGAL;
    case (op_in)
      OP_RTYPE: begin
        case (func_in)
          FN_NOP:                                 instr_class_c = CLS_NOP;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  instr_class_c = CLS_RTYPE;
          default:                                instr_class_c = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: instr_class_c = CLS_ADDI;
      OP_LW:   instr_class_c = CLS_LOAD;
      OP_SW:   instr_class_c = CLS_STORE;
      OP_BEQ:  instr_class_c = CLS_BEQ;
      OP_J:    instr_class_c = CLS_J;
      default: instr_class_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM for the multi-cycle MIPS datapath.
// Memory phases wait on mem_ready; retire pulses on every return to FETCH.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to park unsupported instructions in TRAP;
// otherwise they retire as NOPs.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_in,
  input  logic [FUNC_W-1:0] func_in,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_source,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_dst,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              retire,
  output logic [CNT_W-1:0]  instr_count,
  output logic              illegal_op
);

  state_t           state_q, state_d;
  instr_class_t     instr_class_c;
  ctl_t             ctl_c, ctl_o;
  logic [CNT_W-1:0] count_q;

  multicycle_decode u_decode (
    .op_in         (op_in),
    .func_in       (func_in),
    .instr_class_c (instr_class_c)
  );

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state control decode
  always_comb begin
    ctl_c   = '0;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_op    = ALU_ADD;
        ctl_c.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctl_c.ir_write = 1'b1;
          ctl_c.pc_write = 1'b1;
          state_d        = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctl_c.alu_src_b = SRCB_IMM_SH2;
        ctl_c.alu_op    = ALU_ADD;
        case (instr_class_c)
          CLS_NOP:   state_d = ST_FETCH;
          CLS_RTYPE: state_d = ST_EXEC_R;
          CLS_ADDI:  state_d = ST_EXEC_I;
          CLS_LOAD,
          CLS_STORE: state_d = ST_MEM_ADDR;
          CLS_BEQ:   state_d = ST_BRANCH;
          CLS_J:     state_d = ST_JUMP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:   state_d = ST_TRAP;
`else
          default:   state_d = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REG;
        ctl_c.alu_op    = ALU_FUNCT;
        state_d         = ST_WB_R;
      end
      ST_WB_R: begin
        ctl_c.reg_dst   = 1'b1;
        ctl_c.reg_write = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_EXEC_I: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALU_ADD;
        state_d         = ST_WB_I;
      end
      ST_WB_I: begin
        ctl_c.reg_write = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALU_ADD;
        state_d         = (instr_class_c == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        ctl_c.mem_to_reg = 1'b1;
        ctl_c.reg_write  = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.i_or_d    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_src_b     = SRCB_REG;
        ctl_c.alu_op        = ALU_SUB;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_source     = PCSRC_ALUOUT;
        state_d             = ST_FETCH;
      end
      ST_JUMP: begin
        ctl_c.pc_write  = 1'b1;
        ctl_c.pc_source = PCSRC_JUMP;
        state_d         = ST_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        ctl_c.illegal_op = 1'b1;
        state_d          = ST_TRAP;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
    // FETCH only leaves to DECODE, so any arrival at FETCH completes an instruction
    ctl_c.retire = (state_q != ST_FETCH) && (state_d == ST_FETCH);
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count_q <= '0;
    else if (ctl_c.retire) count_q <= count_q + CNT_W'(1);
  end

  // Controls are forced low for the whole reset window, asynchronously
  assign ctl_o = rst ? '0 : ctl_c;

  assign pc_write      = ctl_o.pc_write;
  assign pc_write_cond = ctl_o.pc_write_cond;
  assign pc_source     = ctl_o.pc_source;
  assign i_or_d        = ctl_o.i_or_d;
  assign mem_read      = ctl_o.mem_read;
  assign mem_write     = ctl_o.mem_write;
  assign ir_write      = ctl_o.ir_write;
  assign alu_src_a     = ctl_o.alu_src_a;
  assign alu_src_b     = ctl_o.alu_src_b;
  assign alu_op        = ctl_o.alu_op;
  assign reg_dst       = ctl_o.reg_dst;
  assign reg_write     = ctl_o.reg_write;
  assign mem_to_reg    = ctl_o.mem_to_reg;
  assign retire        = ctl_o.retire;
  assign illegal_op    = ctl_o.illegal_op;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences; every cycle pushes the
// hand-written expected control word and count, a negedge monitor pops and checks.
// Honours MULTICYCLE_ILLEGAL_TRAP_EN for the illegal-instruction sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_in, func_in;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        alu_src_a, reg_dst, reg_write, mem_to_reg, retire, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .op_in         (op_in),
    .func_in       (func_in),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .retire        (retire),
    .instr_count   (instr_count),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Column order: pw pwc ps(2) iod mr mw irw asa asb(2) aop(2) rd rw m2r ret ill
  localparam logic [17:0] W_ZERO     = 18'b0_0_00_0_0_0_0_0_00_00_0_0_0_0_0;
  localparam logic [17:0] W_FETCH_W  = 18'b0_0_00_0_1_0_0_0_01_00_0_0_0_0_0;
  localparam logic [17:0] W_FETCH_R  = 18'b1_0_00_0_1_0_1_0_01_00_0_0_0_0_0;
  localparam logic [17:0] W_DECODE   = 18'b0_0_00_0_0_0_0_0_11_00_0_0_0_0_0;
  localparam logic [17:0] W_DEC_RET  = 18'b0_0_00_0_0_0_0_0_11_00_0_0_0_1_0;
  localparam logic [17:0] W_EXEC_R   = 18'b0_0_00_0_0_0_0_1_00_10_0_0_0_0_0;
  localparam logic [17:0] W_WB_R     = 18'b0_0_00_0_0_0_0_0_00_00_1_1_0_1_0;
  localparam logic [17:0] W_EXEC_I   = 18'b0_0_00_0_0_0_0_1_10_00_0_0_0_0_0;
  localparam logic [17:0] W_WB_I     = 18'b0_0_00_0_0_0_0_0_00_00_0_1_0_1_0;
  localparam logic [17:0] W_MEM_RD   = 18'b0_0_00_1_1_0_0_0_00_00_0_0_0_0_0;
  localparam logic [17:0] W_WB_MEM   = 18'b0_0_00_0_0_0_0_0_00_00_0_1_1_1_0;
  localparam logic [17:0] W_MEM_WR_W = 18'b0_0_00_1_0_1_0_0_00_00_0_0_0_0_0;
  localparam logic [17:0] W_MEM_WR_R = 18'b0_0_00_1_0_1_0_0_00_00_0_0_0_1_0;
  localparam logic [17:0] W_BRANCH   = 18'b0_1_01_0_0_0_0_1_00_01_0_0_0_1_0;
  localparam logic [17:0] W_JUMP     = 18'b1_0_10_0_0_0_0_0_00_00_0_0_0_1_0;
  localparam logic [17:0] W_TRAP     = 18'b0_0_00_0_0_0_0_0_00_00_0_0_0_0_1;
  localparam int unsigned RET_BIT = 1;

  typedef struct {
    logic [17:0] ctl;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_count = 0;
  logic [5:0]  cur_op = 6'd0, cur_fn = 6'd0;

  // One clock cycle of stimulus plus its expected response
  task automatic cyc(input logic r, input logic rdy, input logic [17:0] w, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rdy;
    op_in     = cur_op;
    func_in   = cur_fn;
    if (r) exp_count = 0;
    e.ctl  = w;
    e.cnt  = exp_count;
    e.name = nm;
    sbq.push_back(e);
    if (w[RET_BIT]) exp_count = exp_count + 32'd1;
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn);
    cur_op = op;
    cur_fn = fn;
  endtask

  task automatic run_rtype(input logic [5:0] fn, input string nm);
    start(6'b000000, fn);
    cyc(0, 1, W_FETCH_R, {nm, ".fetch"});
    cyc(0, 1, W_DECODE,  {nm, ".decode"});
    cyc(0, 1, W_EXEC_R,  {nm, ".exec"});
    cyc(0, 1, W_WB_R,    {nm, ".wb"});
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg, retire, illegal_op};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        failures++;
        $display("FAIL %s instr_count: got %0d expected %0d", e.name, instr_count, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; op_in = '0; func_in = '0;
    cyc(1, 0, W_ZERO, "reset0");
    cyc(1, 1, W_ZERO, "reset1");

    // SW interrupted by reset while waiting in MEM_WR
    start(6'b101011, 6'd0);
    cyc(0, 1, W_FETCH_R,  "swr.fetch");
    cyc(0, 1, W_DECODE,   "swr.decode");
    cyc(0, 1, W_EXEC_I,   "swr.addr");
    cyc(0, 0, W_MEM_WR_W, "swr.memwr");
    cyc(1, 0, W_ZERO,     "swr.rst_mid");
    cyc(1, 1, W_ZERO,     "swr.rst_hold");

    run_rtype(6'b100000, "add");

    // LW with two wait cycles in MEM_RD: 7 cycles total
    start(6'b100011, 6'd0);
    cyc(0, 1, W_FETCH_R, "lw.fetch");
    cyc(0, 1, W_DECODE,  "lw.decode");
    cyc(0, 1, W_EXEC_I,  "lw.addr");
    cyc(0, 0, W_MEM_RD,  "lw.rd_wait0");
    cyc(0, 0, W_MEM_RD,  "lw.rd_wait1");
    cyc(0, 1, W_MEM_RD,  "lw.rd_done");
    cyc(0, 1, W_WB_MEM,  "lw.wb");

    start(6'b000100, 6'd0);
    cyc(0, 1, W_FETCH_R, "beq.fetch");
    cyc(0, 1, W_DECODE,  "beq.decode");
    cyc(0, 1, W_BRANCH,  "beq.branch");
    start(6'b000010, 6'd0);
    cyc(0, 1, W_FETCH_R, "j.fetch");
    cyc(0, 1, W_DECODE,  "j.decode");
    cyc(0, 1, W_JUMP,    "j.jump");

    start(6'b000000, 6'b000000);
    cyc(0, 1, W_FETCH_R, "nop.fetch");
    cyc(0, 1, W_DEC_RET, "nop.decode");

    // ADDI with one wait cycle in FETCH
    start(6'b001000, 6'd0);
    cyc(0, 0, W_FETCH_W, "addi.fetch_wait");
    cyc(0, 1, W_FETCH_R, "addi.fetch");
    cyc(0, 1, W_DECODE,  "addi.decode");
    cyc(0, 1, W_EXEC_I,  "addi.exec");
    cyc(0, 1, W_WB_I,    "addi.wb");

    start(6'b101011, 6'd0);
    cyc(0, 1, W_FETCH_R,  "sw.fetch");
    cyc(0, 1, W_DECODE,   "sw.decode");
    cyc(0, 1, W_EXEC_I,   "sw.addr");
    cyc(0, 0, W_MEM_WR_W, "sw.wr_wait");
    cyc(0, 1, W_MEM_WR_R, "sw.wr_done");

    run_rtype(6'b100010, "sub");
    run_rtype(6'b100100, "and");
    run_rtype(6'b100101, "or");
    run_rtype(6'b101010, "slt");

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    start(6'b111111, 6'd0);
    cyc(0, 1, W_FETCH_R, "ill.fetch");
    cyc(0, 1, W_DECODE,  "ill.decode");
    cyc(0, 1, W_TRAP,    "ill.trap0");
    cyc(0, 1, W_TRAP,    "ill.trap1");
    cyc(0, 0, W_TRAP,    "ill.trap2");
    cyc(1, 1, W_ZERO,    "ill.rst");
    start(6'b000000, 6'b111111);
    cyc(0, 1, W_FETCH_R, "illfn.fetch");
    cyc(0, 1, W_DECODE,  "illfn.decode");
    cyc(0, 1, W_TRAP,    "illfn.trap");
`else
    start(6'b111111, 6'd0);
    cyc(0, 1, W_FETCH_R, "ill.fetch");
    cyc(0, 1, W_DEC_RET, "ill.decode");
    start(6'b000000, 6'b111111);
    cyc(0, 1, W_FETCH_R, "illfn.fetch");
    cyc(0, 1, W_DEC_RET, "illfn.decode");
`endif

    // Let the monitor drain, then check the count after the last retire edge
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (instr_count !== exp_count) begin
      failures++;
      $display("FAIL final_count: got %0d expected %0d", instr_count, exp_count);
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath, replacing single-cycle decode with a state machine that shares one ALU and one memory port across fetch, decode, execute, memory and writeback phases. It consumes the opcode/funct fields of the instruction register and drives every datapath mux select and write strobe. It also handles a variable-latency memory via a ready handshake and reports instruction retirement.

## Interface
- Parameters: none (encodings fixed in package)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op_in  in  6  opcode from instruction register (valid from DECODE onward)
- func_in  in  6  funct field from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write / pc_write_cond  out  1  unconditional / branch-qualified PC load
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read / mem_write  out  1  memory strobes, held until mem_ready
- ir_write  out  1  load instruction register
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- reg_dst / reg_write / mem_to_reg  out  1  writeback controls
- retire  out  1  one-cycle pulse per completed instruction
- instr_count  out  32  retired-instruction count
- illegal_op  out  1  trap flag (see Configuration)

## Operation
- Supported: R-type (op 000000) ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010; ADDI 001000; LW 100011; SW 101011; BEQ 000100; J 000010; NOP = op 0 and func 0.
- Moore decode from state; only ir_write, pc_write in FETCH and state advance in FETCH/MEM_RD/MEM_WR are qualified by mem_ready. Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; on mem_ready: ir_write=1, pc_write=1, next DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next: NOP -> FETCH (retire); other op 0 -> EXEC_R; ADDI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ -> BRANCH; J -> JUMP; other -> see Configuration.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R. WB_R: reg_dst=1, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I. WB_I: reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> WB_MEM. WB_MEM: mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- retire=1 in the cycle any state transitions to FETCH; instr_count increments same edge, wraps 0xFFFFFFFF -> 0.

## Timing
- Reset: state=FETCH, instr_count=0, illegal_op=0; all outputs forced 0 while rst=1; first fetch strobe in the first cycle after release.
- Reset mid-instruction abandons it immediately: no retire, no count, strobes drop asynchronously.
- Latency with mem_ready tied 1: NOP 2, BEQ/J 3, R-type/ADDI/SW 4, LW 5 cycles. Each mem_ready-low cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- mem_read/mem_write and i_or_d stay stable while waiting; memory must not see a strobe drop before mem_ready.

## Configuration
- MULTICYCLE_ILLEGAL_TRAP_EN defined: unsupported opcode, or op 0 with unsupported funct, goes DECODE -> TRAP; TRAP drives all controls 0, illegal_op=1, no retire, exits only on rst.
- Undefined: such instructions go DECODE -> FETCH with retire (executed as NOP); illegal_op tied 0, TRAP state absent.

## Structure
- Package multicycle_pkg: opcode and funct constants, state enumeration, alu_op, alu_src_b and pc_source encodings.
- One sub-module: multicycle_decode, combinational classification of op_in/func_in into instruction class (NOP, RTYPE, ADDI, LOAD, STORE, BEQ, J, ILLEGAL).

## Test plan
- ADD (op 0, func 100000), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; reg_dst=1 & reg_write=1 in cycle 4; retire cycle 4; instr_count=1.
- LW with mem_ready low 2 cycles in MEM_RD -> mem_read and i_or_d=1 held 3 cycles, then WB_MEM mem_to_reg=1; total 7 cycles.
- BEQ then J -> pc_write_cond=1 with alu_op=01, pc_source=01; then pc_write=1, pc_source=10; each 3 cycles; instr_count=2.
- NOP (op 0, func 0) -> retire in DECODE cycle, no reg_write/mem strobe; 2 cycles.
- rst asserted during MEM_WR -> mem_write drops same cycle, instr_count unchanged, FETCH resumes after release.
- Opcode 111111 -> with MULTICYCLE_ILLEGAL_TRAP_EN illegal_op=1 held, no further fetch; without it, retire after DECODE.
